// File: rtl/dl_pipe_adder.sv
// dl_pipe_adder -- pipelined add/subtract unit.
//
// A NUM_BITS-wide add is split into NUM_STAGES chunks of CW = NUM_BITS/NUM_STAGES
// bits. Each registered stage adds one chunk and hands its carry to the next
// stage. Both sides use valid/ready handshakes with full backpressure.
//
// Parameters:
//   NUM_BITS   operand/result width (must be a multiple of NUM_STAGES)
//   NUM_STAGES pipeline depth, 1..NUM_BITS
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand handshake
//   in_a, in_b, in_sub   operands; in_sub=1 selects A-B
//   out_valid/out_ready  result handshake
//   out_sum              result (mod 2^NUM_BITS, or saturated, see below)
//   out_cout             carry out of MSB (sub: 1 = no borrow)
//   out_ovf              signed two's-complement overflow
//
// Build option:
//   DL_PIPE_ADDER_SAT_EN  when defined, out_sum saturates to the most
//                         positive/negative value on signed overflow.

module dl_pipe_adder #(
  parameter int unsigned NUM_BITS   = 32,
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_a,
  input  logic [NUM_BITS-1:0] in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf
);

  localparam int unsigned NS   = (NUM_STAGES == 0) ? 1 : NUM_STAGES;
  localparam int unsigned CW   = NUM_BITS / NS;
  localparam int unsigned LAST = NS - 1;
  localparam int unsigned MSB  = NUM_BITS - 1;

  localparam logic [NUM_BITS-1:0] SAT_POS = {NUM_BITS{1'b1}} >> 1;
  localparam logic [NUM_BITS-1:0] SAT_NEG = ~SAT_POS;

  if (NUM_STAGES < 1 || NUM_STAGES > NUM_BITS || (NUM_BITS % NS) != 0) begin : g_param_check
    $error("dl_pipe_adder: NUM_BITS (%0d) must be a multiple of NUM_STAGES (%0d), 1 <= NUM_STAGES <= NUM_BITS",
           NUM_BITS, NUM_STAGES);
  end

  // Per-stage state. Operands travel whole; chunks below the current stage
  // are never consumed again downstream.
  logic [NS-1:0]       v_q, v_d;
  logic [NS-1:0]       c_q, c_d;
  logic [NUM_BITS-1:0] sum_q [NS];
  logic [NUM_BITS-1:0] sum_d [NS];
  logic [NUM_BITS-1:0] a_q   [NS];
  logic [NUM_BITS-1:0] a_d   [NS];
  logic [NUM_BITS-1:0] b_q   [NS];
  logic [NUM_BITS-1:0] b_d   [NS];
  logic                ovf_q, ovf_d;

  // Inputs seen by each stage (stage 0: ports, stage k: stage k-1 registers).
  logic [NS-1:0]       up_v;
  logic [NS-1:0]       up_c;
  logic [NUM_BITS-1:0] up_s [NS];
  logic [NUM_BITS-1:0] up_a [NS];
  logic [NUM_BITS-1:0] up_b [NS];
  logic [CW:0]         chunk [NS];

  logic [NS-1:0]       rdy;
  logic                rdy_acc;

  // Ready chain, walked from the output back to the input so that an empty
  // stage accepts even while everything downstream is stalled.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_ready;
    for (int unsigned i = 0; i < NS; i++) begin
      rdy_acc      = !v_q[LAST-i] || rdy_acc;
      rdy[LAST-i]  = rdy_acc;
    end
  end

  // Sub mode is folded into the operand at entry: B_eff = ~B, carry-in = 1.
  always_comb begin
    up_v[0] = in_valid;
    up_c[0] = in_sub;
    up_s[0] = '0;
    up_a[0] = in_a;
    up_b[0] = in_sub ? ~in_b : in_b;
    for (int unsigned k = 1; k < NS; k++) begin
      up_v[k] = v_q[k-1];
      up_c[k] = c_q[k-1];
      up_s[k] = sum_q[k-1];
      up_a[k] = a_q[k-1];
      up_b[k] = b_q[k-1];
    end
  end

  always_comb begin
    v_d   = v_q;
    c_d   = c_q;
    sum_d = sum_q;
    a_d   = a_q;
    b_d   = b_q;
    ovf_d = ovf_q;
    for (int unsigned k = 0; k < NS; k++) begin
      chunk[k] = {1'b0, up_a[k][CW*k +: CW]} + {1'b0, up_b[k][CW*k +: CW]}
               + {{CW{1'b0}}, up_c[k]};
      if (rdy[k]) begin
        v_d[k]                 = up_v[k];
        c_d[k]                 = chunk[k][CW];
        sum_d[k]               = up_s[k];
        sum_d[k][CW*k +: CW]   = chunk[k][CW-1:0];
        a_d[k]                 = up_a[k];
        b_d[k]                 = up_b[k];
      end
    end
    if (rdy[LAST]) begin
      ovf_d = (up_a[LAST][MSB] == up_b[LAST][MSB]) && (sum_d[LAST][MSB] != up_a[LAST][MSB]);
`ifdef DL_PIPE_ADDER_SAT_EN
      // Saturation sits in front of the final register, so latency is unchanged.
      if (ovf_d) begin
        sum_d[LAST] = up_a[LAST][MSB] ? SAT_NEG : SAT_POS;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < NS; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k < NS; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: doc/dl_pipe_adder.md
Name: dl_pipe_adder

Overview:
Parametrised, pipelined add/subtract unit and the successor to the single-cycle combinational adder in the design library. Splits a NUM_BITS add into NUM_STAGES equal chunks, one chunk per registered stage, with carry rippling stage to stage. Used in timing-critical datapaths (ALU wide ops, address generation) where a full-width carry chain will not close timing. Has valid/ready handshakes on both sides with full backpressure, and reports carry-out and signed overflow per result.

Parameters:
NUM_BITS, 32, operand/result width; must be a multiple of NUM_STAGES (elaboration error otherwise).
NUM_STAGES, 4, pipeline depth = number of chunks; 1 <= NUM_STAGES <= NUM_BITS; chunk width CW = NUM_BITS/NUM_STAGES.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands presented.
in_ready  output  1  unit accepts operands this cycle.
in_a  input  NUM_BITS  operand A.
in_b  input  NUM_BITS  operand B.
in_sub  input  1  0: A+B; 1: A-B.
out_valid  output  1  result presented.
out_ready  input  1  consumer accepts result this cycle.
out_sum  output  NUM_BITS  result, modulo 2^NUM_BITS.
out_cout  output  1  carry out of MSB (for sub: 1 = no borrow, i.e. A >= B unsigned).
out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low. Reset clears every stage valid bit and every data/carry/flag register to 0. Out of reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
- Input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
- Sub mode: B_eff = ~in_b, carry-in = 1. Add mode: B_eff = in_b, carry-in = 0. B_eff and mode travel with the op.
- Stage k (0..NUM_STAGES-1) adds chunk k of A and B_eff plus the carry registered by stage k-1 (stage 0 uses carry-in). It registers:
  - sum bits [CW*(k+1)-1:0];
  - upper operand chunks still to be added;
  - carry-out;
  - A and B_eff MSBs.
- Last stage registers drive out_*. out_cout = final carry. out_ovf = (A_msb == B_eff_msb) & (sum_msb != A_msb).
- Latency: a result is valid exactly NUM_STAGES cycles after acceptance, with no stalls. Throughput: one op per cycle when out_ready is held high.
- Per-stage valid bit v[k]. ready[k] = !v[k] | ready[k+1]; ready[last] = out_ready; in_ready = ready[0] (combinational chain).
- A stage loads when ready[k]. Its valid becomes the upstream transfer (stage 0: in_valid & in_ready).
- Backpressure: when out_ready=0 and the pipe is full, in_ready=0 and all registers hold. Bubbles collapse: an empty stage accepts even while downstream stalls.
- Data order is strictly preserved; no op is dropped or duplicated.
- Simultaneous output consume and input accept while full: both transfer and the pipe stays full.
- Boundary cases:
  - A + B wraps: out_sum = (A+B) mod 2^NUM_BITS, cout=1.
  - A - A: sum 0, cout=1, ovf=0.
  - 0 - 1: sum all-ones, cout=0.
- NUM_STAGES=1: single registered stage, latency 1, same handshake.
- Reset mid-operation: all in-flight ops are discarded; no spurious out_valid after reset release.
- Out-of-handshake hold: out_sum/out_cout/out_ovf stay stable while out_valid=1 & out_ready=0.

Optional Feature:
DL_PIPE_ADDER_SAT_EN
- Defined: when signed overflow occurs, out_sum saturates. Positive overflow (A_msb=0) gives 0x7F..F; negative overflow gives 0x80..0. out_ovf still reads 1 and out_cout is unchanged. The saturation mux applies after the last stage adder, inside the final register stage, so latency is unchanged.
- Not defined: out_sum wraps modulo 2^NUM_BITS.

Test Plan:
- NUM_BITS=8, NUM_STAGES=2, out_ready=1: send 0x3C+0x15 -> at cycle 2, sum=0x51, cout=0, ovf=0. Back-to-back 0xFF+0x01 next cycle -> sum=0x00, cout=1, ovf=0.
- Carry crosses chunk boundary: 0x0F+0x01 -> sum=0x10. Sub 0x10-0x01 -> sum=0x0F, cout=1. Sub 0x00-0x01 -> sum=0xFF, cout=0.
- Signed overflow: 0x7F+0x01 -> ovf=1; sum=0x80 without the macro, 0x7F with DL_PIPE_ADDER_SAT_EN. Sub 0x80-0x01 -> ovf=1; sum=0x7F (wrap) or 0x80 (sat).
- Backpressure: hold out_ready=0 and stream 5 ops -> in_ready drops after exactly NUM_STAGES accepts. Release -> all results emerge in order, one per cycle, with no loss or duplication. Then random in_valid/out_ready for 10k ops checked against a reference model.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 ops in the pipe -> out_valid=0 and out_sum=0 immediately. After release, in_ready=1 and no stale result appears.
- NUM_BITS=32, NUM_STAGES=1 and NUM_STAGES=32: 0xFFFFFFFF+0x00000001 -> sum=0, cout=1, with latency 1 and 32 cycles respectively.
